// File: rtl/seg6_pkg.sv
// seg6_pkg: shared constants for the six-digit 7-segment scan driver.
//   NUM_DIGITS : digits on the display (fixed at 6)
//   SEL_W      : width of the digit-selector select
//   SEG_OFF    : all segments dark, {dp,g,f,e,d,c,b,a}, active-low
//   AN_OFF     : all anodes off, active-low
//   HEX_SEG    : active-low {g,f,e,d,c,b,a} codes for hex digits 0..F
package seg6_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned SEL_W      = 3;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [5:0] AN_OFF  = 6'b111111;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex7seg_dec.sv
// hex7seg_dec: combinational hex digit to 7-segment decoder.
//   dig : 4-bit hex value
//   seg : active-low segments {g,f,e,d,c,b,a}
module hex7seg_dec
    import seg6_pkg::*;
(
    input  logic [3:0] dig,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[dig];

endmodule

// File: rtl/seg6_scan_driver.sv
// seg6_scan_driver: time-multiplexed six-digit 7-segment display driver.
// Drives the digit selector with a scan counter, decodes the returned digit
// and drives one active-low anode at a time. Outputs are registered, so an/seg
// show the sel/dig_in of the previous cycle.
//   clk    : system clock
//   rst    : synchronous reset, active-high
//   en     : scan enable; low blanks the display and freezes the scan
//   dig_in : digit value returned by the selector for the current sel
//   blank  : per-digit blank, bit k high turns digit k off
//   point  : per-digit decimal point, bit k high lights DP of digit k
//   sel    : select to the digit selector, 0..5
//   an     : anodes, active-low
//   seg    : segments {dp,g,f,e,d,c,b,a}, active-low
// Build option: define SEG6_GHOST_BLANK_EN to insert one dark cycle on every
// digit change to suppress ghosting.
module seg6_scan_driver
    import seg6_pkg::*;
#(
    parameter int unsigned CLK_DIV_W  = 17,
    parameter int unsigned NUM_DIGITS = seg6_pkg::NUM_DIGITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [3:0]       dig_in,
    input  logic [5:0]       blank,
    input  logic [5:0]       point,
    output logic [SEL_W-1:0] sel,
    output logic [5:0]       an,
    output logic [7:0]       seg
);

    logic [CLK_DIV_W-1:0] pre_q;
    logic [SEL_W-1:0]     sel_q;
    logic [5:0]           an_q, an_d;
    logic [7:0]           seg_q, seg_d;
    logic                 tick;
    logic                 sel_valid;
    logic [6:0]           dec_seg;

    assign tick      = en & (&pre_q);
    assign sel_valid = (sel_q < SEL_W'(NUM_DIGITS));

    hex7seg_dec u_dec (
        .dig (dig_in),
        .seg (dec_seg)
    );

    // Prescaler and scan counter; both hold while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            sel_q <= '0;
        end else if (en) begin
            pre_q <= pre_q + 1'b1;
            if (tick) begin
                // >= also recovers from the unused codes 6 and 7
                sel_q <= (sel_q >= SEL_W'(NUM_DIGITS - 1)) ? '0 : sel_q + 1'b1;
            end
        end
    end

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if (en && sel_valid && !blank[sel_q]) begin
            an_d  = ~(6'b000001 << sel_q);
            seg_d = {~point[sel_q], dec_seg};
        end
`ifdef SEG6_GHOST_BLANK_EN
        // Dark for the first cycle the new sel is out, while anode and
        // segments would otherwise still show the previous digit.
        if (tick) begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign sel = sel_q;
    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg6_scan_driver.sv
module tb_seg6_scan_driver;

    localparam int unsigned DIV_W = 2;
    localparam int unsigned PMAX  = (1 << DIV_W) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] dig_in;
    logic [5:0] blank;
    logic [5:0] point;
    logic [2:0] sel;
    logic [5:0] an;
    logic [7:0] seg;

    // Digit selector model: D0..D5.
    logic [3:0] digits [6];

    // Active-low {g..a} codes, written out independently of the RTL package.
    logic [6:0] hex_ref [16];

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard of expected {an, seg}, pushed as inputs are applied.
    logic [13:0] exp_q [$];

    // Bench-side model of prescaler and scan counter.
    int unsigned m_pre = 0;
    int unsigned m_sel = 0;

    seg6_scan_driver #(
        .CLK_DIV_W (DIV_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .dig_in (dig_in),
        .blank  (blank),
        .point  (point),
        .sel    (sel),
        .an     (an),
        .seg    (seg)
    );

    always #5 clk = ~clk;

    assign dig_in = (sel < 3'd6) ? digits[sel] : 4'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply current inputs for one clock, then compare outputs against the
    // expectation pushed for that edge.
    task automatic step();
        logic        tk;
        logic [5:0]  e_an;
        logic [7:0]  e_seg;
        logic [5:0]  onehot;
        logic [13:0] got_exp;

        tk = en && (m_pre == PMAX);
        if (rst || !en || blank[m_sel]) begin
            e_an  = 6'h3F;
            e_seg = 8'hFF;
        end else begin
            onehot = 6'b000001 << m_sel;
            e_an   = ~onehot;
            e_seg  = {~point[m_sel], hex_ref[digits[m_sel]]};
        end
`ifdef SEG6_GHOST_BLANK_EN
        if (!rst && tk) begin
            e_an  = 6'h3F;
            e_seg = 8'hFF;
        end
`endif
        exp_q.push_back({e_an, e_seg});

        if (rst) begin
            m_pre = 0;
            m_sel = 0;
        end else if (en) begin
            m_pre = (m_pre + 1) & PMAX;
            if (tk) m_sel = (m_sel == 5) ? 0 : m_sel + 1;
        end

        @(posedge clk);
        #1;
        got_exp = exp_q.pop_front();
        check("an",  32'(an),  32'(got_exp[13:8]));
        check("seg", 32'(seg), 32'(got_exp[7:0]));
        check("sel", 32'(sel), m_sel);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        hex_ref[0]  = 7'h40; hex_ref[1]  = 7'h79; hex_ref[2]  = 7'h24; hex_ref[3]  = 7'h30;
        hex_ref[4]  = 7'h19; hex_ref[5]  = 7'h12; hex_ref[6]  = 7'h02; hex_ref[7]  = 7'h78;
        hex_ref[8]  = 7'h00; hex_ref[9]  = 7'h10; hex_ref[10] = 7'h08; hex_ref[11] = 7'h03;
        hex_ref[12] = 7'h46; hex_ref[13] = 7'h21; hex_ref[14] = 7'h06; hex_ref[15] = 7'h0E;

        digits[0] = 4'h0; digits[1] = 4'h1; digits[2] = 4'hA;
        digits[3] = 4'hB; digits[4] = 4'hE; digits[5] = 4'hF;

        rst   = 1'b1;
        en    = 1'b1;
        blank = 6'b000000;
        point = 6'b000000;

        // Reset held for 3 cycles, then a full scan plus wrap with decode.
        #1;
        run(3);
        rst = 1'b0;
        run(30);

        // Decimal point on digit 2, digit 5 blanked.
        point = 6'b000100;
        blank = 6'b100000;
        run(26);
        point = 6'b000000;
        blank = 6'b000000;

        // Freeze the scan partway through digit 3.
        for (int i = 0; i < 40 && !(m_sel == 3 && m_pre == 1); i++) step();
        en = 1'b0;
        run(10);
        en = 1'b1;
        run(12);

        // Reset mid-scan with a partial prescaler count.
        for (int i = 0; i < 40 && !(m_sel == 4 && m_pre == 2); i++) step();
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(30);

        // Random digits, points, blanks and enable toggles.
        for (int i = 0; i < 120; i++) begin
            for (int k = 0; k < 6; k++) digits[k] = 4'($urandom_range(0, 15));
            point = 6'($urandom);
            blank = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b000000;
            en    = ($urandom_range(0, 7) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
